// File: rtl/data_ram_ctrl_pkg.sv
// Shared encodings for the big-endian data RAM controller:
// access sizes, FSM states and the byte-offset to lane mapping.
package data_ram_ctrl_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  typedef enum logic {
    FSM_INIT = 1'b0,
    FSM_RUN  = 1'b1
  } fsm_state_e;

  // Big-endian: byte offset o of a word lives in lane banks-1-o (and vice versa).
  function automatic int be_lane(input int off, input int banks);
    return banks - 1 - off;
  endfunction

endpackage

// File: rtl/data_ram_bank.sv
// One byte-wide synchronous RAM bank with a registered read port.
// Reads return the contents from before a same-cycle write.
module data_ram_bank #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_ctrl.sv
// Handshaked, byte-banked, big-endian data memory for the MEM stage:
// zero-fills after reset, then serves one aligned load/store per cycle.
module data_ram_ctrl
  import data_ram_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int BANKS = DATA_W / 8;
  localparam int OW    = $clog2(BANKS);
  localparam int AW    = $clog2(DEPTH);

  fsm_state_e  state_q;
  logic [AW-1:0] cnt_q;
  logic        req_ready_q;

  logic          accept;
  logic [AW-1:0] saddr;
  logic [OW-1:0] off;
  logic          err_d;
  logic [BANKS-1:0]      lane_we;
  logic [BANKS-1:0][7:0] lane_wd;
  int            nb_w;
  int            k_w;

  logic                  init_phase;
  logic [AW-1:0]         bank_addr;
  logic [BANKS-1:0]      bank_we;
  logic [BANKS-1:0][7:0] bank_wd;
  logic [BANKS-1:0][7:0] rd_word;

  logic          vld_q;
  logic          we_q;
  logic          err_q;
  logic          sgn_q;
  logic [1:0]    size_q;
  logic [OW-1:0] off_q;

  int            nb_r;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ext;

  if (ADDR_W > AW + OW) begin : g_unused
    logic unused_addr;
    assign unused_addr = ^req_addr[ADDR_W-1:AW+OW];
  end

  // Zero-fill walks every word once after reset, then the controller stays in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FSM_INIT;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
    end else begin
      case (state_q)
        FSM_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q     <= FSM_RUN;
            req_ready_q <= 1'b1;
          end
        end
        FSM_RUN: begin
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= FSM_INIT;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign accept    = req_valid && req_ready_q;
  assign saddr     = req_addr[AW+OW-1:OW];
  assign off       = req_addr[OW-1:0];

  always_comb begin
    nb_w    = 1 << req_size;
    err_d   = ((DATA_W == 32) && (req_size == SIZE_D)) || ((int'(off) % nb_w) != 0);
    lane_we = '0;
    lane_wd = '0;
    k_w     = 0;
    for (int l = 0; l < BANKS; l++) begin
      k_w = be_lane(l, BANKS) - int'(off);
      if (k_w >= 0 && k_w < nb_w) begin
        lane_we[l] = 1'b1;
        lane_wd[l] = 8'(req_wdata >> (8 * (nb_w - 1 - k_w)));
      end
    end
  end

  assign init_phase = (state_q == FSM_INIT);
  assign bank_addr  = init_phase ? cnt_q : saddr;
  assign bank_wd    = init_phase ? '0 : lane_wd;

  // A reset sampled on the same edge suppresses any write, fill or store.
  always_comb begin
    bank_we = '0;
    if (!rst) begin
      if (init_phase) begin
        bank_we = '1;
      end else if (accept && req_we && !err_d) begin
        bank_we = lane_we;
      end
    end
  end

  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    data_ram_bank #(
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_bank (
      .clk     (clk),
      .we_i    (bank_we[g]),
      .addr_i  (bank_addr),
      .wdata_i (bank_wd[g]),
      .rdata_o (rd_word[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      we_q   <= 1'b0;
      err_q  <= 1'b0;
      sgn_q  <= 1'b0;
      size_q <= '0;
      off_q  <= '0;
    end else begin
      vld_q <= accept;
      if (accept) begin
        we_q   <= req_we;
        err_q  <= err_d;
        sgn_q  <= req_signed;
        size_q <= req_size;
        off_q  <= off;
      end
    end
  end

  // Shift the addressed bytes to the top, then right-justify; the field MSB is shifted's MSB.
  always_comb begin
    nb_r    = 1 << size_q;
    shifted = rd_word << (8 * int'(off_q));
    ext     = '0;
    if (!err_q) begin
      ext = shifted >> (DATA_W - 8 * nb_r);
      if (sgn_q && shifted[DATA_W-1]) begin
        ext = ext | ({DATA_W{1'b1}} << (8 * nb_r));
      end
    end
  end

  assign rsp_valid = vld_q;
  assign rsp_err   = vld_q && err_q;
  assign rsp_rdata = (vld_q && !we_q && !err_q) ? ext : '0;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Self-checking bench: directed MEM-stage scenarios plus random traffic
// checked against a byte-addressed big-endian memory model.
module tb_data_ram_ctrl;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;
  localparam int BYTES  = DEPTH * (DATA_W / 8);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  int totalCount = 0;
  int badCount   = 0;

  logic [7:0] refMem [BYTES];

  data_ram_ctrl #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    totalCount++;
    if (got !== exp) begin
      badCount++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory model: memory is a flat byte array, byte addr a at index a mod BYTES.
  task automatic modelAccess(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic err, output logic [31:0] data);
    int n;
    int base;
    logic [63:0] v;
    n    = 1 << size;
    base = int'(addr % BYTES);
    err  = (size == 2'd3) || ((addr % n) != 0);
    data = '0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < n; k++) refMem[base + k] = 8'(wdata >> (8 * (n - 1 - k)));
      end else begin
        v = '0;
        for (int k = 0; k < n; k++) v = (v << 8) | 64'(refMem[base + k]);
        if (sgn && v[8 * n - 1]) v = v | (~64'd0 << (8 * n));
        data = v[31:0];
      end
    end
  endtask

  task automatic clearModel;
    for (int i = 0; i < BYTES; i++) refMem[i] = 8'h00;
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata);
    logic        expErr;
    logic [31:0] expData;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    checkOutput("ready", req_ready, 1);
    @(posedge clk);
    modelAccess(we, size, sgn, addr, wdata, expErr, expData);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rspValid", rsp_valid, 1);
    checkOutput("rspErr", rsp_err, expErr);
    checkOutput("rspData", rsp_rdata, expData);
  endtask

  task automatic idleCycle;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("idleValid", rsp_valid, 0);
    checkOutput("idleErr", rsp_err, 0);
    checkOutput("idleData", rsp_rdata, 0);
  endtask

  // Called at a negedge right after rst drops; counts cycles with req_ready low.
  task automatic waitInit;
    int lowCycles;
    lowCycles = 0;
    while (req_ready !== 1'b1 && lowCycles < 4 * DEPTH + 8) begin
      lowCycles++;
      @(negedge clk);
    end
    checkOutput("initLen", lowCycles, DEPTH);
  endtask

  task automatic resetDut(input int cycles);
    rst       = 1'b1;
    req_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("rstReady", req_ready, 0);
    checkOutput("rstValid", rsp_valid, 0);
    checkOutput("rstData", rsp_rdata, 0);
    checkOutput("rstErr", rsp_err, 0);
    clearModel();
    rst = 1'b0;
    waitInit();
  endtask

  initial begin
    logic        we;
    logic        sgn;
    logic [1:0]  sz;
    logic [31:0] addr;
    int          n;

    @(negedge clk);
    resetDut(2);

    // Preload ones, then reset and expect the zero-fill to clear them.
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    checkOutput("preload", rsp_rdata, 32'hFFFF_FFFF);
    resetDut(2);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    checkOutput("zeroFill", rsp_rdata, 32'h0);

    applyStimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678);
    applyStimulus(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    checkOutput("lb13", rsp_rdata, 32'h0000_0078);
    applyStimulus(1'b0, 2'd0, 1'b1, 32'h10, 32'h0);
    checkOutput("lb10", rsp_rdata, 32'h0000_0012);
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_8001);
    applyStimulus(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    checkOutput("lh12", rsp_rdata, 32'hFFFF_8001);
    applyStimulus(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    checkOutput("lhu12", rsp_rdata, 32'h0000_8001);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    checkOutput("lw10", rsp_rdata, 32'h1234_8001);

    applyStimulus(1'b0, 2'd1, 1'b1, 32'h11, 32'h0);
    checkOutput("misLh", rsp_err, 1);
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h12, 32'hDEAD_BEEF);
    checkOutput("misSw", rsp_err, 1);
    applyStimulus(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
    checkOutput("badSize", rsp_err, 1);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    checkOutput("lw10Kept", rsp_rdata, 32'h1234_8001);

    applyStimulus(1'b1, 2'd2, 1'b0, 32'h20, 32'hA5A5_A5A5);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    checkOutput("raw20", rsp_rdata, 32'hA5A5_A5A5);

    applyStimulus(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFE_F00D);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h00, 32'h0);
    checkOutput("wrap", rsp_rdata, 32'hCAFE_F00D);
    idleCycle();

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) idleCycle();
      we   = 1'($urandom_range(0, 1));
      sgn  = 1'($urandom_range(0, 1));
      sz   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      n    = 1 << sz;
      addr = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(n - 1);
      applyStimulus(we, sz, sgn, addr, $urandom);
    end

    // Reset sampled on the same edge a load would be accepted.
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h8, 32'h0BAD_CAFE);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_size   = 2'd2;
    req_signed = 1'b0;
    req_addr   = 32'h8;
    rst        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("midRstValid", rsp_valid, 0);
    checkOutput("midRstReady", req_ready, 0);
    clearModel();
    rst = 1'b0;
    waitInit();
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    checkOutput("midRstFill", rsp_rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
